zap_wb_pt_responder: RTL and testbench

Wishbone classic-cycle responder (slave) that serves page-table descriptor fetches and other word accesses from an internal word-organised RAM.
It is the memory-side counterpart to the MMU page-walk initiator. It is used as the page-table store in subsystem benches and as a small on-chip descriptor memory in integration.
Supports programmable wait states, byte-enabled writes, an optional read-only mode, address-window decode with error response, and a backdoor load port for preloading L1/L2 tables.

---
 rtl/zap_wb_pt_pkg.sv | 21 ++
 rtl/zap_wb_pt_ram.sv | 49 ++++
 rtl/zap_wb_pt_responder.sv | 160 ++++++++++++++++
 tb/tb_zap_wb_pt_responder.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zap_wb_pt_pkg.sv
// Shared types and constants for the Wishbone page-table responder.
package zap_wb_pt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Wait-state counter width, sized for 0..15 idle cycles.
    localparam int unsigned WS_W = $clog2(16);

    localparam logic [3:0] SEL_ALL = 4'b1111;

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_ACK  = 2'd1,
        RSP_ERR  = 2'd2
    } rsp_e;

endpackage

// File: rtl/zap_wb_pt_ram.sv
// Word RAM with a byte-enabled read/write port and a full-word write port
// that overrides it on the same word; reads return pre-edge contents.
module zap_wb_pt_ram #(
    parameter int unsigned DEPTH = 1024
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_a_en,
    input  logic                     i_a_wen,
    input  logic [3:0]               i_a_sel,
    input  logic [$clog2(DEPTH)-1:0] i_a_idx,
    input  logic [31:0]              i_a_dat,
    output logic [31:0]              o_a_dat,
    input  logic                     i_b_wen,
    input  logic [$clog2(DEPTH)-1:0] i_b_idx,
    input  logic [31:0]              i_b_dat
);

    logic [31:0] mem [DEPTH];
    logic [31:0] q;

    // Port B is assigned last so a same-word collision resolves to its data.
    always_ff @(posedge i_clk) begin
        if (i_a_en && i_a_wen) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (i_a_sel[i]) begin
                    mem[i_a_idx][8*i +: 8] <= i_a_dat[8*i +: 8];
                end
            end
        end
        if (i_b_wen) begin
            mem[i_b_idx] <= i_b_dat;
        end
    end

    // Read register doubles as the bus data output: zero unless a read completes.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            q <= '0;
        end else if (i_a_en && !i_a_wen) begin
            q <= mem[i_a_idx];
        end else begin
            q <= '0;
        end
    end

    always_comb o_a_dat = q;

endmodule

// File: rtl/zap_wb_pt_responder.sv
// Wishbone classic responder serving page-table words from internal RAM,
// with programmable wait states, window decode and a backdoor load port.
module zap_wb_pt_responder
    import zap_wb_pt_pkg::*;
#(
    parameter int unsigned DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_4000,
    parameter int unsigned WAIT_STATES = 1,
    parameter bit          READ_ONLY   = 1'b0
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_wb_cyc,
    input  logic                     i_wb_stb,
    input  logic                     i_wb_wen,
    input  logic [3:0]               i_wb_sel,
    input  logic [31:0]              i_wb_adr,
    input  logic [31:0]              i_wb_dat,
    output logic [31:0]              o_wb_dat,
    output logic                     o_wb_ack,
    output logic                     o_wb_err,
    input  logic                     i_bd_wen,
    input  logic [$clog2(DEPTH)-1:0] i_bd_adr,
    input  logic [31:0]              i_bd_dat,
    output logic                     o_busy
);

    localparam int unsigned AW = $clog2(DEPTH);

    state_e          state;
    logic [WS_W-1:0] cnt;
    logic [AW-1:0]   req_idx;
    logic [3:0]      req_sel;
    logic [31:0]     req_dat;
    logic            req_wen;
    logic            req_hit;
    logic            ack_q;
    logic            err_q;
    logic            busy_q;

    logic            start;
    logic            live_hit;
    logic            cur_hit;
    logic            cur_wen;
    logic [AW-1:0]   cur_idx;
    logic [3:0]      cur_sel;
    logic [31:0]     cur_dat;
    logic            to_resp;
    rsp_e            rsp_nxt;
    logic            ram_en;
    logic [3:0]      ram_sel;
    logic            bd_wen;
    logic            unused_adr;

    // With zero wait states the response is decided from the live bus in IDLE,
    // otherwise from the request captured on entry to WAIT.
    always_comb begin
        start    = i_wb_cyc & i_wb_stb;
        live_hit = (i_wb_adr[31:AW+2] == BASE_ADDR[31:AW+2]);
        if (state == IDLE) begin
            cur_hit = live_hit;
            cur_wen = i_wb_wen;
            cur_idx = i_wb_adr[AW+1:2];
            cur_sel = i_wb_sel;
            cur_dat = i_wb_dat;
        end else begin
            cur_hit = req_hit;
            cur_wen = req_wen;
            cur_idx = req_idx;
            cur_sel = req_sel;
            cur_dat = req_dat;
        end

        to_resp = 1'b0;
        case (state)
            IDLE:    to_resp = start && (WAIT_STATES == 0);
            WAIT:    to_resp = start && (cnt == WS_W'(1));
            default: to_resp = 1'b0;
        endcase

        rsp_nxt = RSP_NONE;
        if (to_resp && i_reset_n) begin
            if (!cur_hit || (cur_wen && READ_ONLY)) begin
                rsp_nxt = RSP_ERR;
            end else begin
                rsp_nxt = RSP_ACK;
            end
        end

        ram_en     = (rsp_nxt == RSP_ACK);
        ram_sel    = cur_wen ? cur_sel : SEL_ALL;
        bd_wen     = i_bd_wen & i_reset_n;
        unused_adr = ^i_wb_adr[1:0];
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state  <= IDLE;
            cnt    <= '0;
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            ack_q <= (rsp_nxt == RSP_ACK);
            err_q <= (rsp_nxt == RSP_ERR);
            case (state)
                IDLE: begin
                    if (start) begin
                        req_idx <= i_wb_adr[AW+1:2];
                        req_sel <= i_wb_sel;
                        req_dat <= i_wb_dat;
                        req_wen <= i_wb_wen;
                        req_hit <= live_hit;
                        cnt     <= WS_W'(WAIT_STATES);
                        busy_q  <= 1'b1;
                        state   <= (WAIT_STATES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (!start) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        cnt <= cnt - WS_W'(1);
                        if (cnt == WS_W'(1)) begin
                            state <= RESP;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    zap_wb_pt_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_a_en    (ram_en),
        .i_a_wen   (cur_wen),
        .i_a_sel   (ram_sel),
        .i_a_idx   (cur_idx),
        .i_a_dat   (cur_dat),
        .o_a_dat   (o_wb_dat),
        .i_b_wen   (bd_wen),
        .i_b_idx   (i_bd_adr),
        .i_b_dat   (i_bd_dat)
    );

    always_comb begin
        o_wb_ack = ack_q;
        o_wb_err = err_q;
        o_busy   = busy_q;
    end

endmodule

// File: tb/tb_zap_wb_pt_responder.sv
// Scoreboard bench: three responder configurations driven with directed and
// random Wishbone traffic, checked against a word-array reference model.
module tb_zap_wb_pt_responder;

    localparam logic [31:0] BASE = 32'h0000_4000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cycle = 0;
    always @(posedge clk) cycle++;

    logic        rst_n  [3];
    logic        cyc    [3];
    logic        stb    [3];
    logic        wen    [3];
    logic [3:0]  sel    [3];
    logic [31:0] adr    [3];
    logic [31:0] wdat   [3];
    logic [31:0] rdat   [3];
    logic        ack    [3];
    logic        err    [3];
    logic        busy   [3];
    logic        bd_wen [3];
    logic [9:0]  bd_adr [3];
    logic [31:0] bd_dat [3];

    zap_wb_pt_responder #(.DEPTH(1024), .BASE_ADDR(BASE), .WAIT_STATES(1), .READ_ONLY(1'b0)) dut0 (
        .i_clk(clk), .i_reset_n(rst_n[0]), .i_wb_cyc(cyc[0]), .i_wb_stb(stb[0]), .i_wb_wen(wen[0]),
        .i_wb_sel(sel[0]), .i_wb_adr(adr[0]), .i_wb_dat(wdat[0]), .o_wb_dat(rdat[0]), .o_wb_ack(ack[0]),
        .o_wb_err(err[0]), .i_bd_wen(bd_wen[0]), .i_bd_adr(bd_adr[0]), .i_bd_dat(bd_dat[0]), .o_busy(busy[0]));

    zap_wb_pt_responder #(.DEPTH(16), .BASE_ADDR(BASE), .WAIT_STATES(3), .READ_ONLY(1'b0)) dut1 (
        .i_clk(clk), .i_reset_n(rst_n[1]), .i_wb_cyc(cyc[1]), .i_wb_stb(stb[1]), .i_wb_wen(wen[1]),
        .i_wb_sel(sel[1]), .i_wb_adr(adr[1]), .i_wb_dat(wdat[1]), .o_wb_dat(rdat[1]), .o_wb_ack(ack[1]),
        .o_wb_err(err[1]), .i_bd_wen(bd_wen[1]), .i_bd_adr(bd_adr[1][3:0]), .i_bd_dat(bd_dat[1]), .o_busy(busy[1]));

    zap_wb_pt_responder #(.DEPTH(16), .BASE_ADDR(BASE), .WAIT_STATES(0), .READ_ONLY(1'b1)) dut2 (
        .i_clk(clk), .i_reset_n(rst_n[2]), .i_wb_cyc(cyc[2]), .i_wb_stb(stb[2]), .i_wb_wen(wen[2]),
        .i_wb_sel(sel[2]), .i_wb_adr(adr[2]), .i_wb_dat(wdat[2]), .o_wb_dat(rdat[2]), .o_wb_ack(ack[2]),
        .o_wb_err(err[2]), .i_bd_wen(bd_wen[2]), .i_bd_adr(bd_adr[2][3:0]), .i_bd_dat(bd_dat[2]), .o_busy(busy[2]));

    function automatic int unsigned ws_of(int d);
        return (d == 0) ? 1 : ((d == 1) ? 3 : 0);
    endfunction

    function automatic int unsigned depth_of(int d);
        return (d == 0) ? 1024 : 16;
    endfunction

    function automatic bit ro_of(int d);
        return (d == 2);
    endfunction

    typedef struct {
        bit          err;
        logic [31:0] dat;
        int unsigned due;
    } exp_t;

    exp_t        sb [3][$];
    exp_t        mon_e;
    logic [31:0] model [3][1024];
    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d actual=%h required=%h", name, d, act, exp);
        end
    endtask

    // Expected outcome from the bus rules: window hit, read-only rejection, byte lanes.
    task automatic issue(input int d, input bit w, input logic [3:0] s, input logic [31:0] a,
                         input logic [31:0] v, input int unsigned extra);
        exp_t        e;
        bit          hit;
        int unsigned idx;
        hit   = (a >= BASE) && (a < BASE + depth_of(d) * 4);
        idx   = (a - BASE) >> 2;
        e.due = cycle + 1 + ws_of(d) + extra;
        e.dat = 32'h0;
        e.err = 1'b0;
        if (!hit || (w && ro_of(d))) begin
            e.err = 1'b1;
        end else if (w) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) model[d][idx][8*b +: 8] = v[8*b +: 8];
            end
        end else begin
            e.dat = model[d][idx];
        end
        sb[d].push_back(e);
        cyc[d] = 1'b1; stb[d] = 1'b1; wen[d] = w; sel[d] = s; adr[d] = a; wdat[d] = v;
    endtask

    task automatic wait_resp(input int d);
        int unsigned n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(ack[d] === 1'b1 || err[d] === 1'b1) && n < 40);
        if (!(ack[d] === 1'b1 || err[d] === 1'b1)) begin
            checks++; errors++;
            $display("FAIL resp_timeout dut%0d waited=%0d required=response within 40 cycles", d, n);
        end
    endtask

    task automatic drain(input int d);
        int unsigned n;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (sb[d].size() != 0 && n < 40);
        if (sb[d].size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout dut%0d pending=%0d required=0", d, sb[d].size());
        end
    endtask

    task automatic release_bus(input int d);
        @(posedge clk); #1;
        cyc[d] = 1'b0; stb[d] = 1'b0;
    endtask

    task automatic xfer(input int d, input bit w, input logic [3:0] s, input logic [31:0] a, input logic [31:0] v);
        @(posedge clk); #1;
        issue(d, w, s, a, v, 0);
        wait_resp(d);
        release_bus(d);
    endtask

    task automatic bd_set(input int d, input int unsigned idx, input logic [31:0] v);
        bd_wen[d] = 1'b1; bd_adr[d] = idx[9:0]; bd_dat[d] = v;
        model[d][idx] = v;
    endtask

    function automatic logic [31:0] rnd_adr(input int d);
        int unsigned r;
        int unsigned span;
        r    = $urandom_range(0, 9);
        span = depth_of(d) * 4;
        if (r < 7)       return BASE + $urandom_range(0, span - 1);
        else if (r == 7) return BASE - 1 - $urandom_range(0, 15);
        else if (r == 8) return BASE + span + $urandom_range(0, 15);
        else             return $urandom;
    endfunction

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (ack[d] === 1'b1 || err[d] === 1'b1) begin
                if (sb[d].size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_resp dut%0d ack=%0b err=%0b required=no response", d, ack[d], err[d]);
                end else begin
                    mon_e = sb[d].pop_front();
                    chk("resp_kind", d, {30'd0, ack[d], err[d]}, mon_e.err ? 32'd1 : 32'd2);
                    chk("resp_cycle", d, cycle, mon_e.due);
                    if (!mon_e.err) chk("resp_data", d, rdat[d], mon_e.dat);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog cycle=%0d required=bench completion", cycle);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst_n[d] = 1'b0; cyc[d] = 1'b0; stb[d] = 1'b0; wen[d] = 1'b0; sel[d] = 4'h0;
            adr[d] = 32'h0; wdat[d] = 32'h0; bd_wen[d] = 1'b0; bd_adr[d] = 10'h0; bd_dat[d] = 32'h0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("rst_ack", d, {31'd0, ack[d]}, 32'd0);
            chk("rst_err", d, {31'd0, err[d]}, 32'd0);
            chk("rst_dat", d, rdat[d], 32'd0);
            chk("rst_busy", d, {31'd0, busy[d]}, 32'd0);
        end
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;

        // Preload every word through the backdoor.
        for (int unsigned i = 0; i < 1024; i++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++) begin
                if (i < depth_of(d)) bd_set(d, i, $urandom);
                else bd_wen[d] = 1'b0;
            end
        end
        @(posedge clk); #1;
        bd_set(0, 0, 32'hDEAD_C0D2);
        bd_set(1, 7, 32'h0707_0707);
        bd_set(2, 0, 32'h2222_0000);
        @(posedge clk); #1;
        bd_set(0, 2, 32'hFFFF_FFFF);
        bd_wen[1] = 1'b0; bd_wen[2] = 1'b0;
        @(posedge clk); #1;
        bd_wen[0] = 1'b0;

        xfer(0, 1'b0, 4'hF, 32'h0000_4000, 32'h0);
        xfer(0, 1'b1, 4'b0101, 32'h0000_4008, 32'h1122_3344);
        xfer(0, 1'b0, 4'h0, 32'h0000_4008, 32'h0);
        xfer(0, 1'b0, 4'hF, 32'h0000_8000, 32'h0);
        xfer(0, 1'b1, 4'hF, 32'h0000_5000, 32'h9999_9999);
        xfer(0, 1'b0, 4'hF, 32'h0000_3FFC, 32'h0);
        xfer(0, 1'b0, 4'hF, 32'h0000_4FFF, 32'h0);
        xfer(0, 1'b0, 4'hF, 32'h0000_4000, 32'h0);
        xfer(2, 1'b1, 4'hF, 32'h0000_4000, 32'h1234_5678);
        xfer(2, 1'b0, 4'hF, 32'h0000_4000, 32'h0);

        // Same-edge backdoor and bus write to word 5: backdoor wins.
        @(posedge clk); #1;
        issue(0, 1'b1, 4'hF, 32'h0000_4014, 32'h5555_5555, 0);
        @(posedge clk); #1;
        bd_set(0, 5, 32'hAAAA_AAAA);
        @(posedge clk); #1;
        bd_wen[0] = 1'b0;
        wait_resp(0);
        release_bus(0);
        xfer(0, 1'b0, 4'hF, 32'h0000_4014, 32'h0);

        // Backdoor write to the word being read returns the old data.
        @(posedge clk); #1;
        issue(0, 1'b0, 4'hF, 32'h0000_4018, 32'h0, 0);
        @(posedge clk); #1;
        bd_set(0, 6, 32'h0BAD_F00D);
        @(posedge clk); #1;
        bd_wen[0] = 1'b0;
        wait_resp(0);
        release_bus(0);
        xfer(0, 1'b0, 4'hF, 32'h0000_4018, 32'h0);

        // Abort in the second wait cycle: nothing committed, bus idle again.
        @(posedge clk); #1;
        cyc[1] = 1'b1; stb[1] = 1'b1; wen[1] = 1'b1; sel[1] = 4'hF; adr[1] = 32'h0000_401C; wdat[1] = 32'h1234_5678;
        @(posedge clk); #1;
        @(negedge clk);
        chk("busy_in_wait", 1, {31'd0, busy[1]}, 32'd1);
        @(posedge clk); #1;
        cyc[1] = 1'b0; stb[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("busy_after_abort", 1, {31'd0, busy[1]}, 32'd0);
        repeat (6) @(posedge clk);
        xfer(1, 1'b0, 4'hF, 32'h0000_401C, 32'h0);

        // Reset during WAIT drops the write and blocks the backdoor.
        @(posedge clk); #1;
        cyc[1] = 1'b1; stb[1] = 1'b1; wen[1] = 1'b1; sel[1] = 4'hF; adr[1] = 32'h0000_400C; wdat[1] = 32'hCAFE_F00D;
        @(posedge clk); #1;
        rst_n[1] = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0;
        bd_wen[1] = 1'b1; bd_adr[1] = 10'd4; bd_dat[1] = 32'h0000_BEEF;
        @(posedge clk); #1;
        bd_wen[1] = 1'b0;
        @(negedge clk);
        chk("midrst_ack", 1, {31'd0, ack[1]}, 32'd0);
        chk("midrst_err", 1, {31'd0, err[1]}, 32'd0);
        chk("midrst_dat", 1, rdat[1], 32'd0);
        chk("midrst_busy", 1, {31'd0, busy[1]}, 32'd0);
        @(posedge clk); #1;
        rst_n[1] = 1'b1;
        repeat (6) @(posedge clk);
        xfer(1, 1'b0, 4'hF, 32'h0000_400C, 32'h0);
        xfer(1, 1'b0, 4'hF, 32'h0000_4010, 32'h0);

        // Zero wait states, strobe held across two reads.
        @(posedge clk); #1;
        issue(2, 1'b0, 4'hF, 32'h0000_4000, 32'h0, 0);
        @(posedge clk); #1;
        issue(2, 1'b0, 4'hF, 32'h0000_4004, 32'h0, 1);
        drain(2);
        release_bus(2);

        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 40; k++) begin
                xfer(d, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rnd_adr(d), $urandom);
            end
        end

        repeat (8) @(posedge clk);
        for (int d = 0; d < 3; d++) chk("sb_empty", d, sb[d].size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
